stacker_ctrl: RTL and testbench

- Game sequencer for the 8x8 stacker LED matrix.
- Animates a bouncing bar on the active row and freezes it on a debounced stop press.
- Trims the frozen bar to its overlap with the row below, then advances upward until the player wins (row 7 placed) or loses (zero overlap).
- Drives the 64-bit map consumed by the matrix driver, and the level consumed by the score display.

---
 rtl/stacker_ctrl.sv | 169 ++++++++++++++++
 tb/tb_stacker_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/stacker_ctrl.sv
// stacker_ctrl: game sequencer for the 8x8 stacker LED matrix.
//   A bar bounces along the active row. A stop press freezes it and
//   trims it to its overlap with the row below. The game then climbs
//   one row, or ends in WIN (row 7 placed) or LOSE (no overlap).
// Ports:
//   clk        system clock, all state on the rising edge
//   btnR       asynchronous active-low reset
//   stop_pulse debounced stop press, one clk cycle wide
//   map        LED image, bit 8*r+c = row r, column c (row 0 at the bottom)
//   level      score level 1..4, derived from the active row
//   active_row row currently animating or last placed
//   game_over  high while in LOSE
//   win        high while in WIN
module stacker_ctrl #(
  parameter int TICK_DIV   = 8,
  parameter int TICK_STEP  = 1,
  parameter int INIT_WIDTH = 3
) (
  input  logic        clk,
  input  logic        btnR,
  input  logic        stop_pulse,
  output logic [63:0] map,
  output logic [2:0]  level,
  output logic [2:0]  active_row,
  output logic        game_over,
  output logic        win
);

  typedef enum logic [1:0] {ST_PLAY, ST_PLACE, ST_WIN, ST_LOSE} state_t;

  localparam int          CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [2:0]  W0   = 3'(INIT_WIDTH);
  localparam logic [63:0] MAP0 = 64'((64'd1 << INIT_WIDTH) - 64'd1);

  state_t        state;
  logic [2:0]    w;
  logic [2:0]    pos;
  logic          dir_left;
  logic [CW-1:0] cnt;

  // The step period shrinks as the game climbs. This table holds the
  // last counter value before the step, one entry per row.
  logic [CW-1:0] last_tick [8];
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_period
      localparam int PERIOD = TICK_DIV - gi * TICK_STEP;
      assign last_tick[gi] = CW'(PERIOD - 1);
    end
  endgenerate

  function automatic logic [7:0] bar_mask(input logic [2:0] width, input logic [2:0] at);
    logic [7:0] m;
    m = (8'd1 << width) - 8'd1;
    return m << at;
  endfunction

  function automatic logic [2:0] level_of(input logic [2:0] row);
    if (row <= 3'd2)      return 3'd1;
    else if (row <= 3'd4) return 3'd2;
    else if (row <= 3'd6) return 3'd3;
    else                  return 3'd4;
  endfunction

  logic [7:0] bar, below, ov, stepped_bar;
  logic [2:0] row_below, row_above, next_pos, ov_w, ov_lsb;
  logic       next_dir_left, tick, at_right;
  logic [3:0] ov_count;

  always_comb begin
    row_below = active_row - 3'd1;
    row_above = active_row + 3'd1;
    bar       = bar_mask(w, pos);
    below     = map[{row_below, 3'b000} +: 8];
    // Row 0 sits on the floor, so the whole bar counts as overlap there.
    ov        = (active_row == 3'd0) ? bar : (bar & below);
    tick      = (cnt == last_tick[active_row]);
    at_right  = (({1'b0, pos} + {1'b0, w}) == 4'd8);

    // The bounce reverses direction and moves one column in the same tick.
    next_dir_left = dir_left;
    next_pos      = pos + 3'd1;
    if (!dir_left) begin
      if (at_right) begin
        next_dir_left = 1'b1;
        next_pos      = pos - 3'd1;
      end
    end else begin
      if (pos == 3'd0) next_dir_left = 1'b0;
      else             next_pos      = pos - 3'd1;
    end
    stepped_bar = bar_mask(w, next_pos);

    ov_count = 4'd0;
    ov_lsb   = 3'd0;
    for (int i = 0; i < 8; i++) ov_count = ov_count + {3'b000, ov[i]};
    for (int i = 7; i >= 0; i--) if (ov[i]) ov_lsb = 3'(i);
    ov_w = ov_count[2:0];  // the overlap is at most the bar width, which is 7 or less
  end

  always_ff @(posedge clk or negedge btnR) begin
    if (!btnR) begin
      state      <= ST_PLAY;
      map        <= MAP0;
      active_row <= 3'd0;
      w          <= W0;
      pos        <= 3'd0;
      dir_left   <= 1'b0;
      cnt        <= '0;
      level      <= 3'd1;
      game_over  <= 1'b0;
      win        <= 1'b0;
    end else begin
      case (state)
        ST_PLAY: begin
          // A stop takes priority over a coincident tick. The bar is
          // captured where it is now shown.
          if (stop_pulse) begin
            state <= ST_PLACE;
          end else if (tick) begin
            cnt      <= '0;
            pos      <= next_pos;
            dir_left <= next_dir_left;
            map[{active_row, 3'b000} +: 8] <= stepped_bar;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_PLACE: begin
          if (ov == 8'd0) begin
            map[{active_row, 3'b000} +: 8] <= 8'd0;
            game_over <= 1'b1;
            state     <= ST_LOSE;
          end else begin
            map[{active_row, 3'b000} +: 8] <= ov;
            if (active_row == 3'd7) begin
              win   <= 1'b1;
              state <= ST_WIN;
            end else begin
              // The trimmed bar starts the next row exactly where it was
              // placed. The direction carries over.
              active_row <= row_above;
              level      <= level_of(row_above);
              w          <= ov_w;
              pos        <= ov_lsb;
              cnt        <= '0;
              map[{row_above, 3'b000} +: 8] <= ov;
              state      <= ST_PLAY;
            end
          end
        end
        default: begin  // ST_WIN, ST_LOSE: hold until a stop press restarts the game
          if (stop_pulse) begin
            state      <= ST_PLAY;
            map        <= MAP0;
            active_row <= 3'd0;
            w          <= W0;
            pos        <= 3'd0;
            dir_left   <= 1'b0;
            cnt        <= '0;
            level      <= 3'd1;
            game_over  <= 1'b0;
            win        <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stacker_ctrl.sv
// Directed testbench for stacker_ctrl (TICK_DIV=8, TICK_STEP=1, INIT_WIDTH=3).
// Inputs are driven and outputs are sampled on the falling clock edge.
module tb_stacker_ctrl;
  logic        clk = 1'b0;
  logic        btnR = 1'b1;
  logic        stop_pulse = 1'b0;
  logic [63:0] map;
  logic [2:0]  level;
  logic [2:0]  active_row;
  logic        game_over;
  logic        win;

  int compared = 0;
  int mismatched = 0;

  stacker_ctrl #(.TICK_DIV(8), .TICK_STEP(1), .INIT_WIDTH(3)) dut (
    .clk(clk), .btnR(btnR), .stop_pulse(stop_pulse), .map(map),
    .level(level), .active_row(active_row), .game_over(game_over), .win(win)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    btnR = 1'b0;
    stop_pulse = 1'b0;
    tick_n(2);
    btnR = 1'b1;
  endtask

  // One-cycle stop pulse. The task returns after the PLACE cycle (or the restart) has completed.
  task automatic press();
    stop_pulse = 1'b1;
    @(negedge clk);
    stop_pulse = 1'b0;
    @(negedge clk);
    $display("press: row=%0d map=%h level=%0d over=%0b win=%0b", active_row, map, level, game_over, win);
  endtask

  task automatic wait_pattern(input int row, input logic [7:0] pat, output bit ok);
    logic [7:0] cur;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      cur = map[8*row +: 8];
      if (cur == pat) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    #1 btnR = 1'b0;
    tick_n(1);
    compared++; if (map !== 64'h7) begin mismatched++; $display("FAIL reset_map: got %h want %h", map, 64'h7); end
    compared++; if (level !== 3'd1) begin mismatched++; $display("FAIL reset_level: got %0d want 1", level); end
    compared++; if (active_row !== 3'd0) begin mismatched++; $display("FAIL reset_row: got %0d want 0", active_row); end
    compared++; if (game_over !== 1'b0) begin mismatched++; $display("FAIL reset_over: got %b want 0", game_over); end
    compared++; if (win !== 1'b0) begin mismatched++; $display("FAIL reset_win: got %b want 0", win); end
    btnR = 1'b1;
    tick_n(20);
    compared++; if (map !== 64'h1C) begin mismatched++; $display("FAIL play_before_reset: got %h want %h", map, 64'h1C); end
    #2 btnR = 1'b0;
    #1;
    compared++; if (map !== 64'h7) begin mismatched++; $display("FAIL async_reset_map: got %h want %h", map, 64'h7); end
    @(negedge clk);
    btnR = 1'b1;
    // Reset while the PLACE cycle is pending.
    stop_pulse = 1'b1;
    @(negedge clk);
    stop_pulse = 1'b0;
    #2 btnR = 1'b0;
    #1;
    compared++; if (map !== 64'h7) begin mismatched++; $display("FAIL reset_in_place_map: got %h want %h", map, 64'h7); end
    @(negedge clk);
    btnR = 1'b1;
    tick_n(2);
    compared++; if (map !== 64'h7) begin mismatched++; $display("FAIL after_place_reset_map: got %h want %h", map, 64'h7); end
    compared++; if (active_row !== 3'd0) begin mismatched++; $display("FAIL after_place_reset_row: got %0d want 0", active_row); end
    $display("test_reset done");
  endtask

  task automatic test_bounce();
    logic [7:0] exp_seq [6];
    exp_seq = '{8'h1C, 8'h38, 8'h70, 8'hE0, 8'h70, 8'h38};
    do_reset();
    tick_n(7);
    compared++; if (map[7:0] !== 8'h07) begin mismatched++; $display("FAIL bounce_pre_tick: got %h want 07", map[7:0]); end
    tick_n(1);
    compared++; if (map[7:0] !== 8'h0E) begin mismatched++; $display("FAIL bounce_step1: got %h want 0e", map[7:0]); end
    for (int i = 0; i < 6; i++) begin
      tick_n(8);
      compared++; if (map[7:0] !== exp_seq[i]) begin mismatched++; $display("FAIL bounce_step%0d: got %h want %h", i + 2, map[7:0], exp_seq[i]); end
    end
    compared++; if (map[63:8] !== 56'd0) begin mismatched++; $display("FAIL bounce_upper_rows: got %h want 0", map[63:8]); end
    $display("test_bounce done");
  endtask

  task automatic test_simul_stop_tick();
    do_reset();
    tick_n(8);
    compared++; if (map[7:0] !== 8'h0E) begin mismatched++; $display("FAIL simul_setup: got %h want 0e", map[7:0]); end
    tick_n(7);
    stop_pulse = 1'b1;          // sampled on the edge where the counter wraps
    @(negedge clk);
    @(negedge clk);             // still high during PLACE, so it must be ignored
    stop_pulse = 1'b0;
    compared++; if (map[7:0] !== 8'h0E) begin mismatched++; $display("FAIL simul_row0: got %h want 0e", map[7:0]); end
    compared++; if (map[15:8] !== 8'h0E) begin mismatched++; $display("FAIL simul_row1: got %h want 0e", map[15:8]); end
    compared++; if (active_row !== 3'd1) begin mismatched++; $display("FAIL simul_row: got %0d want 1", active_row); end
    tick_n(3);
    compared++; if (active_row !== 3'd1) begin mismatched++; $display("FAIL place_stop_ignored_row: got %0d want 1", active_row); end
    compared++; if (map[15:8] !== 8'h0E) begin mismatched++; $display("FAIL place_stop_ignored_map: got %h want 0e", map[15:8]); end
    $display("test_simul_stop_tick done");
  endtask

  task automatic test_perfect_stack();
    bit ok;
    do_reset();
    wait_pattern(0, 8'h1C, ok);
    compared++; if (!ok) begin mismatched++; $display("FAIL stack_wait_row0: got timeout want 1c"); end
    press();
    compared++; if (map[15:0] !== 16'h1C1C) begin mismatched++; $display("FAIL stack_row0: got %h want 1c1c", map[15:0]); end
    compared++; if (active_row !== 3'd1) begin mismatched++; $display("FAIL stack_row_idx1: got %0d want 1", active_row); end
    wait_pattern(1, 8'h1C, ok);
    press();
    compared++; if (map[23:8] !== 16'h1C1C) begin mismatched++; $display("FAIL stack_row1: got %h want 1c1c", map[23:8]); end
    compared++; if (active_row !== 3'd2) begin mismatched++; $display("FAIL stack_row_idx2: got %0d want 2", active_row); end
    compared++; if (level !== 3'd1) begin mismatched++; $display("FAIL stack_level: got %0d want 1", level); end
    $display("test_perfect_stack done");
  endtask

  task automatic test_trim();
    bit ok;
    do_reset();
    wait_pattern(0, 8'h1C, ok);
    press();
    wait_pattern(1, 8'h38, ok);
    compared++; if (!ok) begin mismatched++; $display("FAIL trim_wait_row1: got timeout want 38"); end
    press();
    compared++; if (map[23:0] !== 24'h18181C) begin mismatched++; $display("FAIL trim_map: got %h want 18181c", map[23:0]); end
    compared++; if (active_row !== 3'd2) begin mismatched++; $display("FAIL trim_row: got %0d want 2", active_row); end
    tick_n(5);
    compared++; if (map[23:16] !== 8'h18) begin mismatched++; $display("FAIL trim_pre_step: got %h want 18", map[23:16]); end
    tick_n(1);
    compared++; if (map[23:16] !== 8'h30) begin mismatched++; $display("FAIL trim_step_w2: got %h want 30", map[23:16]); end
    $display("test_trim done");
  endtask

  task automatic test_lose_restart();
    bit ok;
    do_reset();
    press();                    // row 0 placed at 07
    wait_pattern(1, 8'h70, ok);
    compared++; if (!ok) begin mismatched++; $display("FAIL lose_wait_row1: got timeout want 70"); end
    press();
    compared++; if (game_over !== 1'b1) begin mismatched++; $display("FAIL lose_over: got %b want 1", game_over); end
    compared++; if (win !== 1'b0) begin mismatched++; $display("FAIL lose_win: got %b want 0", win); end
    compared++; if (map !== 64'h7) begin mismatched++; $display("FAIL lose_map: got %h want %h", map, 64'h7); end
    compared++; if (active_row !== 3'd1) begin mismatched++; $display("FAIL lose_row: got %0d want 1", active_row); end
    tick_n(10);
    compared++; if (map !== 64'h7 || game_over !== 1'b1) begin mismatched++; $display("FAIL lose_hold: got map=%h over=%b want 7/1", map, game_over); end
    press();
    compared++; if (map !== 64'h7) begin mismatched++; $display("FAIL restart_map: got %h want %h", map, 64'h7); end
    compared++; if (game_over !== 1'b0 || active_row !== 3'd0) begin mismatched++; $display("FAIL restart_state: got over=%b row=%0d want 0/0", game_over, active_row); end
    tick_n(7);
    compared++; if (map !== 64'hE) begin mismatched++; $display("FAIL restart_play: got %h want %h", map, 64'hE); end
    $display("test_lose_restart done");
  endtask

  task automatic test_win();
    bit ok;
    logic [2:0] exp_level [8];
    exp_level = '{3'd1, 3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd4};
    do_reset();
    for (int k = 0; k < 7; k++) begin
      wait_pattern(k, 8'h1C, ok);
      compared++; if (!ok) begin mismatched++; $display("FAIL win_wait_row%0d: got timeout want 1c", k); end
      press();
      compared++; if (active_row !== 3'(k + 1) || level !== exp_level[k + 1]) begin
        mismatched++; $display("FAIL win_climb%0d: got row=%0d level=%0d want %0d/%0d", k, active_row, level, k + 1, exp_level[k + 1]);
      end
    end
    wait_pattern(7, 8'h1C, ok);
    press();
    compared++; if (win !== 1'b1 || game_over !== 1'b0) begin mismatched++; $display("FAIL win_flags: got win=%b over=%b want 1/0", win, game_over); end
    compared++; if (map !== 64'h1C1C1C1C1C1C1C1C) begin mismatched++; $display("FAIL win_map: got %h want 1c1c1c1c1c1c1c1c", map); end
    compared++; if (level !== 3'd4 || active_row !== 3'd7) begin mismatched++; $display("FAIL win_level: got level=%0d row=%0d want 4/7", level, active_row); end
    tick_n(5);
    compared++; if (map !== 64'h1C1C1C1C1C1C1C1C || win !== 1'b1) begin mismatched++; $display("FAIL win_hold: got map=%h win=%b", map, win); end
    press();
    compared++; if (map !== 64'h7 || win !== 1'b0 || level !== 3'd1) begin mismatched++; $display("FAIL win_restart: got map=%h win=%b level=%0d want 7/0/1", map, win, level); end
    $display("test_win done");
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_simul_stop_tick();
    test_perfect_stack();
    test_trim();
    test_lose_restart();
    test_win();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
